parity_check_4bit: RTL and testbench
====================================

// Module: parity_check_4bit
// PURPOSE
//  Registered checker for a 4-bit data word with one received parity bit.
//  Even or odd parity is selected per word. Each checked word produces a
//  one-cycle-latency error flag.
//  Also keeps a sticky error flag and a saturating error counter.
//  Sits on the receive side of a narrow link, after the word/parity capture stage.
// PARAMETERS
//  DATA_W  4  data word width in bits (checked bits = data only, parity separate)
//  CNT_W   8  width of the saturating error counter
// PORTS
//  clk          in   1        rising-edge clock, single domain
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        data/parity/parity_mode valid this cycle
//  data         in   DATA_W   received data word
//  parity       in   1        received parity bit
//  parity_mode  in   1        0 = even parity, 1 = odd parity
//  clr          in   1        synchronous clear of err_sticky and err_count
//  out_valid    out  1        error is a fresh result for the word of previous cycle
//  error        out  1        1 = parity mismatch on checked word
//  err_sticky   out  1        set by any mismatch, held until clr or reset
//  err_count    out  CNT_W    number of mismatches since clr/reset, saturating
// BEHAVIOUR
//  - Check function: mismatch = (^data) ^ parity ^ parity_mode.
//    - Even mode: the total count of ones over data+parity must be even.
//    - Odd mode: that count must be odd.
//  - Reset (rst_n=0, async assert; release synchronised upstream): all outputs 0.
//  - Latency: 1 cycle.
//    - If in_valid=1 at edge N: out_valid=1 and error=mismatch after edge N.
//    - If in_valid=0 at edge N: out_valid=0 and error=0 after edge N.
//  - No backpressure; one word per cycle, back-to-back accepted.
//  - err_sticky: set at edge when in_valid & mismatch; cleared only by clr/reset.
//  - err_count: +1 at edge when in_valid & mismatch; holds at 2^CNT_W-1 (no wrap).
//  - clr=1 at edge: err_sticky<=0, err_count<=0; clr wins over same-cycle mismatch
//    (that mismatch is not counted or latched into sticky).
//  - clr does not affect error/out_valid pipeline; same-cycle word still reported.
//  - Inputs ignored (no state change) when in_valid=0, except clr.
//  - Reset mid-stream: in-flight result discarded, outputs 0 immediately.
// TESTING
//  1 data=0110 mode=0 parity=0 valid -> next cycle out_valid=1 error=0
//  2 data=0110 mode=0 parity=1 valid -> error=1, err_sticky=1, err_count=1
//  3 data=0110 mode=1 parity=1 valid -> error=0; data=0110 mode=1 parity=0 -> error=1,
//    err_count=2
//  4 data=0111 mode=0 parity=1 valid -> error=0; in_valid=0 next -> out_valid=0 error=0
//  5 force 300 mismatches (CNT_W=8) -> err_count stops at 255; clr with mismatch
//    same cycle -> err_count=0, err_sticky=0, error=1 reported
//  6 assert rst_n=0 mid-stream between edges -> all outputs 0 without waiting for clk

Source files
------------

// File: rtl/parity_check_4bit.sv
// Purpose: registered even/odd parity checker with sticky flag and saturating error counter.
// Latency: 1 cycle from an in_valid word to out_valid/error; sticky/count update on the same edge.
// Backpressure: none; accepts one word per cycle back-to-back, never stalls.
module parity_check_4bit #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              parity,
  input  logic              parity_mode,
  input  logic              clr,
  output logic              out_valid,
  output logic              error,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count
);

  // All-ones counter value; the counter parks here instead of wrapping.
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic mismatch;
  logic hit;
  logic cnt_at_max;

  // Odd total ones over data+parity is wrong in even mode and right in odd
  // mode, so xor-ing the mode in turns "odd count" into "mismatch".
  always_comb begin
    mismatch   = (^data) ^ parity ^ parity_mode;
    hit        = in_valid & mismatch;
    cnt_at_max = (err_count == CNT_MAX);
  end

  // Result pipeline: reports every accepted word, independent of clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      error     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      error     <= hit;
    end
  end

  // Sticky flag: clr takes priority over a mismatch arriving the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (clr) begin
      err_sticky <= 1'b0;
    end else if (hit) begin
      err_sticky <= 1'b1;
    end
  end

  // Saturating mismatch counter: clr wins, otherwise count up until all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr) begin
      err_count <= '0;
    end else if (hit && !cnt_at_max) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_check_4bit.sv
module tb_parity_check_4bit;

  localparam int DATA_W  = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              parity = 1'b0;
  logic              parity_mode = 1'b0;
  logic              clr = 1'b0;
  logic              out_valid;
  logic              error;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic m_ov, m_err, m_sticky;
  int   m_count;

  parity_check_4bit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data(data),
    .parity(parity), .parity_mode(parity_mode), .clr(clr),
    .out_valid(out_valid), .error(error), .err_sticky(err_sticky),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] obs();
    return {out_valid, error, err_sticky, err_count};
  endfunction

  function automatic logic [10:0] expv();
    return {m_ov, m_err, m_sticky, 8'(m_count)};
  endfunction

  task automatic model_reset();
    m_ov = 0; m_err = 0; m_sticky = 0; m_count = 0;
  endtask

  // Drive one cycle of inputs, take the edge, advance the model from the rules:
  // a word is wrong when its ones-count parity differs from the selected mode.
  task automatic clock_word(input logic v, input logic [DATA_W-1:0] d,
                            input logic p, input logic m, input logic c);
    bit mis;
    in_valid = v; data = d; parity = p; parity_mode = m; clr = c;
    @(posedge clk);
    mis   = (($countones({d, p}) % 2) != int'(m));
    m_ov  = v;
    m_err = v && mis;
    if (c) begin
      m_sticky = 0; m_count = 0;
    end else if (v && mis) begin
      m_sticky = 1;
      if (m_count < CNT_MAX) m_count++;
    end
    #1;
    in_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 11'd0) begin
      errors++; $display("FAIL reset_state got %h want %h", obs(), 11'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    // case 1: even mode, balanced word
    clock_word(1, 4'b0110, 0, 0, 0);
    checks++;
    if ({out_valid, error, err_sticky, err_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++; $display("FAIL case1 got %h want %h", obs(), {1'b1, 1'b0, 1'b0, 8'd0});
    end
    // case 2: even mode, wrong parity
    clock_word(1, 4'b0110, 1, 0, 0);
    checks++;
    if ({out_valid, error, err_sticky, err_count} !== {1'b1, 1'b1, 1'b1, 8'd1}) begin
      errors++; $display("FAIL case2 got %h want %h", obs(), {1'b1, 1'b1, 1'b1, 8'd1});
    end
    // case 3: odd mode, good then bad
    clock_word(1, 4'b0110, 1, 1, 0);
    checks++;
    if ({out_valid, error, err_count} !== {1'b1, 1'b0, 8'd1}) begin
      errors++; $display("FAIL case3a got %h want %h", obs(), {1'b1, 1'b0, 1'b1, 8'd1});
    end
    clock_word(1, 4'b0110, 0, 1, 0);
    checks++;
    if ({out_valid, error, err_sticky, err_count} !== {1'b1, 1'b1, 1'b1, 8'd2}) begin
      errors++; $display("FAIL case3b got %h want %h", obs(), {1'b1, 1'b1, 1'b1, 8'd2});
    end
    // case 4: odd-weight data with parity 1 in even mode, then an idle cycle
    clock_word(1, 4'b0111, 1, 0, 0);
    checks++;
    if ({out_valid, error, err_count} !== {1'b1, 1'b0, 8'd2}) begin
      errors++; $display("FAIL case4a got %h want %h", obs(), {1'b1, 1'b0, 1'b1, 8'd2});
    end
    // idle cycle carrying a would-be mismatch must change nothing
    clock_word(0, 4'b0001, 0, 0, 0);
    checks++;
    if ({out_valid, error, err_sticky, err_count} !== {1'b0, 1'b0, 1'b1, 8'd2}) begin
      errors++; $display("FAIL case4b_idle got %h want %h", obs(), {1'b0, 1'b0, 1'b1, 8'd2});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clock_word(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 15) == 0));
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random_%0d got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_back_to_back();
    // Alternate good/bad words every cycle in both modes
    for (int i = 0; i < 32; i++) begin
      logic [DATA_W-1:0] d;
      logic m, p;
      d = 4'(i);
      m = 1'(i >> 1);
      p = 1'(i) ^ m ^ 1'($countones(d) % 2);
      clock_word(1, d, p, m, 0);
      checks++;
      if (obs() !== expv() || error !== 1'(i)) begin
        errors++; $display("FAIL b2b_%0d got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_saturation();
    clock_word(0, 0, 0, 0, 1);
    checks++;
    if ({err_sticky, err_count} !== 9'd0) begin
      errors++; $display("FAIL clr_idle got %h want %h", {err_sticky, err_count}, 9'd0);
    end
    for (int i = 0; i < 300; i++) begin
      clock_word(1, 4'b0001, 0, 0, 0);
      if (i == 253) begin
        checks++;
        if (err_count !== 8'd254) begin
          errors++; $display("FAIL sat_254 got %0d want 254", err_count);
        end
      end
      if (i == 254) begin
        checks++;
        if (err_count !== 8'd255) begin
          errors++; $display("FAIL sat_255 got %0d want 255", err_count);
        end
      end
    end
    checks++;
    if ({error, err_sticky, err_count} !== {1'b1, 1'b1, 8'd255}) begin
      errors++; $display("FAIL sat_300 got %h want %h", obs(), {1'b1, 1'b1, 1'b1, 8'd255});
    end
    // clr beats a same-cycle mismatch, which is still reported on error
    clock_word(1, 4'b0001, 0, 0, 1);
    checks++;
    if ({out_valid, error, err_sticky, err_count} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL clr_priority got %h want %h", obs(), {1'b1, 1'b1, 1'b0, 8'd0});
    end
  endtask

  task automatic test_async_reset();
    clock_word(1, 4'b1000, 0, 0, 0);
    checks++;
    if (obs() !== expv() || error !== 1'b1) begin
      errors++; $display("FAIL pre_reset got %h want %h", obs(), expv());
    end
    // a mismatch word is in flight when reset lands between edges
    in_valid = 1'b1; data = 4'b1000; parity = 1'b0; parity_mode = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 11'd0) begin
      errors++; $display("FAIL async_reset got %h want %h", obs(), 11'd0);
    end
    @(posedge clk); #1;
    checks++;
    if (obs() !== 11'd0) begin
      errors++; $display("FAIL reset_held got %h want %h", obs(), 11'd0);
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    clock_word(1, 4'b1100, 1, 1, 0);
    checks++;
    if (obs() !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++; $display("FAIL post_reset got %h want %h", obs(), {1'b1, 1'b0, 1'b0, 8'd0});
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
